// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: FSM state encoding and default timing,
// used by both the serializer and the deserializer.
package serial_link_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_STROBE_CYCLES   = 10;
    localparam int DEFAULT_GAP_CYCLES      = 10;
    localparam int DEFAULT_WORD_GAP_CYCLES = 300;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_STROBE,
        ST_GAP,
        ST_WORD_GAP
    } link_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One counter serves every phase, so it is sized for the longest of them.
    function automatic int timer_width(input int strobe_cycles, input int gap_cycles,
                                       input int word_gap_cycles);
        int w;
        w = $clog2(max3(strobe_cycles, gap_cycles, word_gap_cycles) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so loading
// N-1 gives a phase that lasts exactly N cycles.
module cycle_timer
    import serial_link_pkg::*;
#(
    parameter int WIDTH = timer_width(DEFAULT_STROBE_CYCLES, DEFAULT_GAP_CYCLES,
                                      DEFAULT_WORD_GAP_CYCLES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: words are shifted out MSB-first, each bit qualified
// by a write_out strobe. Define SERIALIZER_TX_PARITY_EN to append an even-parity bit.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | ready_out high, waiting for valid_in
//   ST_WAIT_RDY  | word latched, waiting for the remote receiver (status_in)
//   ST_STROBE    | write_out high, data_out carries the current bit
//   ST_GAP       | write_out low, data_out held; shift at the end
//   ST_WORD_GAP  | idle spacing after the last bit before ready_out returns
module serializer_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int STROBE_CYCLES   = DEFAULT_STROBE_CYCLES,
    parameter int GAP_CYCLES      = DEFAULT_GAP_CYCLES,
    parameter int WORD_GAP_CYCLES = DEFAULT_WORD_GAP_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  status_in,
    output logic                  data_out,
    output logic                  write_out,
    output logic                  busy_out,
    output logic [7:0]            words_sent_out
);

`ifdef SERIALIZER_TX_PARITY_EN
    localparam int NUM_BITS = DATA_WIDTH + 1;
`else
    localparam int NUM_BITS = DATA_WIDTH;
`endif

    localparam int TW = timer_width(STROBE_CYCLES, GAP_CYCLES, WORD_GAP_CYCLES);
    localparam int CW = $clog2(NUM_BITS + 1);

    localparam bit            HAS_WORD_GAP  = (WORD_GAP_CYCLES > 0);
    localparam logic [TW-1:0] STROBE_LOAD   = TW'(STROBE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD      = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] WORD_GAP_LOAD = TW'(HAS_WORD_GAP ? WORD_GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LAST_BIT      = CW'(NUM_BITS - 1);

    link_state_e         state;
    logic [NUM_BITS-1:0] shift_reg;
    logic [NUM_BITS-1:0] load_word;
    logic [CW-1:0]       bit_cnt;

    logic          timer_done;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          last_bit;
    logic          start_strobe;
    logic          start_gap;
    logic          start_word_gap;

`ifdef SERIALIZER_TX_PARITY_EN
    assign load_word = {data_in, ^data_in};
`else
    assign load_word = data_in;
`endif

    // Timer reloads happen on the same edge as the state change they time.
    always_comb begin
        last_bit       = (bit_cnt == LAST_BIT);
        start_strobe   = ((state == ST_WAIT_RDY) && status_in) ||
                         ((state == ST_GAP) && timer_done && !last_bit);
        start_gap      = (state == ST_STROBE) && timer_done;
        start_word_gap = HAS_WORD_GAP && (state == ST_GAP) && timer_done && last_bit;

        timer_load  = start_strobe || start_gap || start_word_gap;
        timer_value = STROBE_LOAD;
        if (start_gap) begin
            timer_value = GAP_LOAD;
        end else if (start_word_gap) begin
            timer_value = WORD_GAP_LOAD;
        end
    end

    cycle_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            ready_out      <= 1'b1;
            data_out       <= 1'b0;
            write_out      <= 1'b0;
            busy_out       <= 1'b0;
            words_sent_out <= '0;
            shift_reg      <= '0;
            bit_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_in && ready_out) begin
                        shift_reg <= load_word;
                        bit_cnt   <= '0;
                        ready_out <= 1'b0;
                        busy_out  <= 1'b1;
                        state     <= ST_WAIT_RDY;
                    end
                end

                ST_WAIT_RDY: begin
                    if (status_in) begin
                        data_out  <= shift_reg[NUM_BITS-1];
                        write_out <= 1'b1;
                        state     <= ST_STROBE;
                    end
                end

                ST_STROBE: begin
                    if (timer_done) begin
                        write_out <= 1'b0;
                        state     <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (timer_done) begin
                        shift_reg <= {shift_reg[NUM_BITS-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + CW'(1);
                        if (last_bit) begin
                            words_sent_out <= words_sent_out + 8'd1;
                            if (HAS_WORD_GAP) begin
                                state <= ST_WORD_GAP;
                            end else begin
                                ready_out <= 1'b1;
                                busy_out  <= 1'b0;
                                state     <= ST_IDLE;
                            end
                        end else begin
                            // Next bit appears together with the rising strobe.
                            data_out  <= shift_reg[NUM_BITS-2];
                            write_out <= 1'b1;
                            state     <= ST_STROBE;
                        end
                    end
                end

                ST_WORD_GAP: begin
                    if (timer_done) begin
                        ready_out <= 1'b1;
                        busy_out  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: default-timing instance for bit/strobe checks and a
// minimum-timing instance (no word gap) for the word-counter wrap.
module tb_serializer_tx;

`ifdef SERIALIZER_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int S = 10;
    localparam int G = 10;
    localparam int W = 300;
    localparam int FAST_PERIOD = 2 + 2 * NB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       status_in = 1'b0;
    logic       ready_out, data_out, write_out, busy_out;
    logic [7:0] words_sent_out;

    logic [7:0] f_data_in = 8'h5A;
    logic       f_valid_in = 1'b0;
    logic       f_status_in = 1'b0;
    logic       f_ready_out, f_data_out, f_write_out, f_busy_out;
    logic [7:0] f_words_sent_out;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    serializer_tx dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .status_in      (status_in),
        .data_out       (data_out),
        .write_out      (write_out),
        .busy_out       (busy_out),
        .words_sent_out (words_sent_out)
    );

    serializer_tx #(
        .DATA_WIDTH      (8),
        .STROBE_CYCLES   (1),
        .GAP_CYCLES      (1),
        .WORD_GAP_CYCLES (0)
    ) dut_fast (
        .clock          (clock),
        .reset          (reset),
        .data_in        (f_data_in),
        .valid_in       (f_valid_in),
        .ready_out      (f_ready_out),
        .status_in      (f_status_in),
        .data_out       (f_data_out),
        .write_out      (f_write_out),
        .busy_out       (f_busy_out),
        .words_sent_out (f_words_sent_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int i);
        if (i < 8) return w[7-i];
        return ^w;
    endfunction

    // Entered on the sample where write_out has just risen for the first bit.
    task automatic capture_word(input string tag, input logic [7:0] w, input int exp_words);
        int   n;
        int   extra;
        logic held;
        for (int i = 0; i < NB; i++) begin
            if (i > 0) begin
                n = 0;
                while (!write_out && n < 1000) begin tick(); n++; end
                check({tag, " gap"}, n, G);
            end
            check({tag, " bit"}, data_out, exp_bit(w, i));
            held = data_out;
            n = 0;
            while (write_out && n < 1000) begin tick(); n++; end
            check({tag, " strobe"}, n, S);
            check({tag, " hold"}, data_out, held);
        end
        n = 0;
        extra = 0;
        while (!ready_out && n < 2000) begin
            tick();
            n++;
            if (write_out) extra++;
        end
        check({tag, " word_gap"}, n, G + W);
        check({tag, " extra_strobes"}, extra, 0);
        check({tag, " words_sent"}, words_sent_out, exp_words);
    endtask

    initial begin
        int   n;
        int   rises;
        logic prev;

        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst ready", ready_out, 1);
        check("rst data", data_out, 0);
        check("rst write", write_out, 0);
        check("rst busy", busy_out, 0);
        check("rst words", words_sent_out, 0);
        check("rst fast ready", f_ready_out, 1);
        check("rst fast words", f_words_sent_out, 0);
        reset = 1'b0;
        tick();
        check("idle ready", ready_out, 1);

        // 0x80 with receiver ready: minimum latency, full timing
        status_in = 1'b1;
        data_in   = 8'h80;
        valid_in  = 1'b1;
        tick();
        valid_in = 1'b0;
        check("w80 ready_drop", ready_out, 0);
        check("w80 busy", busy_out, 1);
        check("w80 no_early_strobe", write_out, 0);
        tick();
        check("w80 latency", write_out, 1);
        capture_word("w80", 8'h80, 1);
        check("w80 idle busy", busy_out, 0);

        // 0xA5 held off by status_in, then status_in dropped mid-word
        status_in = 1'b0;
        data_in   = 8'hA5;
        valid_in  = 1'b1;
        tick();
        valid_in = 1'b0;
        rises = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (write_out) rises++;
        end
        check("wA5 held strobes", rises, 0);
        check("wA5 held busy", busy_out, 1);
        check("wA5 held ready", ready_out, 0);
        status_in = 1'b1;
        tick();
        check("wA5 release", write_out, 1);
        status_in = 1'b0;
        capture_word("wA5", 8'hA5, 2);

        // Back-to-back 0x80..0x87 with valid_in held throughout
        status_in = 1'b1;
        data_in   = 8'h80;
        valid_in  = 1'b1;
        for (int w = 0; w < 8; w++) begin
            tick();
            check("b2b accept", ready_out, 0);
            data_in = 8'(8'h81 + w);
            tick();
            check("b2b first_strobe", write_out, 1);
            capture_word("b2b", 8'(8'h80 + w), 3 + w);
        end
        valid_in = 1'b0;

`ifdef SERIALIZER_TX_PARITY_EN
        data_in  = 8'h07;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        capture_word("par07", 8'h07, 11);
        data_in  = 8'h03;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        capture_word("par03", 8'h03, 12);
`endif

        // Reset during bit 4 of 0xFF
        data_in  = 8'hFF;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        check("rst_mid first_strobe", write_out, 1);
        rises = 0;
        n = 0;
        while (rises < 4 && n < 1000) begin
            prev = write_out;
            tick();
            n++;
            if (write_out && !prev) rises++;
        end
        check("rst_mid reach_bit4", rises, 4);
        tick();
        tick();
        tick();
        check("rst_mid in_strobe", write_out, 1);
        check("rst_mid bit", data_out, 1);
        reset = 1'b1;
        tick();
        check("rst_mid write", write_out, 0);
        check("rst_mid data", data_out, 0);
        check("rst_mid ready", ready_out, 1);
        check("rst_mid busy", busy_out, 0);
        check("rst_mid words", words_sent_out, 0);
        reset = 1'b0;
        rises = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (write_out) rises++;
        end
        check("rst_mid no_strobes", rises, 0);
        check("rst_mid ready_after", ready_out, 1);

        // Minimum-timing instance: counter wrap after 256 words
        f_status_in = 1'b1;
        f_valid_in  = 1'b1;
        for (int k = 0; k < FAST_PERIOD * 255 - 1; k++) tick();
        check("fast words_254", f_words_sent_out, 254);
        check("fast busy", f_busy_out, 1);
        tick();
        check("fast words_255", f_words_sent_out, 255);
        check("fast ready_no_gap", f_ready_out, 1);
        for (int k = 0; k < FAST_PERIOD; k++) tick();
        check("fast words_wrap", f_words_sent_out, 0);
        f_valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
